mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
Inverse of the main control decoder. Accepts a control-signal bundle (Jump, MemWrite, RegWrite, RegDest, ALUSrc, MemtoReg, Branch, ALUOp) plus operand fields, recovers the opcode and packs a 32-bit MIPS word. Writes the words sequentially into instruction memory through a one-stage registered write port. Used to load programs and to round-trip check the decoder: encode, then decode, then compare.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, maximum words written per program (must be at most 2^ADDR_W)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a program load at word address 0
in_valid  input  1  input bundle valid
in_ready  output  1  encoder can accept a bundle this cycle
in_last  input  1  marks the final instruction of the program
Jump, MemWrite, RegWrite, RegDest, ALUSrc, MemtoReg, Branch  input  1 each  control bundle
ALUOp  input  2  control bundle
rs, rt, rd  input  5 each  register fields
funct  input  6  R-type function field
imm  input  16  I-type immediate
target  input  26  J-type target
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  word address
imem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written so far
busy  output  1  state is RUN
done  output  1  program load completed (sticky until start or rst)
err  output  1  illegal bundle seen (sticky until start or rst)
err_cnt  output  8  illegal bundles dropped (ILLEGAL_SKIP_EN only; otherwise tied to 0)

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. in_ready, imem_we, busy, done and err are 0. imem_addr, imem_wdata, count and err_cnt are 0. rst overrides every other input, including mid-program.
- States: IDLE, RUN, DONE, ERR.
  - IDLE or DONE or ERR with start=1: go to RUN; clear count, done, err and err_cnt; write pointer = 0.
  - RUN with an accepted bundle that has in_last=1: go to DONE.
  - RUN with the accepted bundle making count reach DEPTH: go to DONE.
  - RUN with an illegal bundle: go to ERR (default build).
  - start while in RUN: ignored.
- in_ready = 1 only in RUN and while count < DEPTH. A transfer occurs on in_valid && in_ready. Throughput is one word per cycle. in_valid=0 stalls with no side effects.
- Opcode recovery: the bundle must exactly match one of six canonical vectors, ordered J,MW,RW,RD,AS,MR,BR,ALUOp:
  - lw: 0,0,1,0,1,1,0,00 -> opcode 100011; word {op,rs,rt,imm}
  - sw: 0,1,0,0,1,1,0,00 -> opcode 101011; word {op,rs,rt,imm}
  - R-type: 0,0,1,1,0,0,0,10 -> opcode 000000; word {op,rs,rt,rd,5'b0,funct}
  - addi: 0,0,1,0,1,0,0,00 -> opcode 001000; word {op,rs,rt,imm}
  - beq: 0,0,0,0,0,0,1,01 -> opcode 000100; word {op,rs,rt,imm}
  - j: 1,0,0,0,0,0,0,00 -> opcode 000010; word {op,target}
  - Any other vector, including all-zero, is illegal.
- Latency: a bundle accepted at edge N gives imem_we=1 during cycle N+1, with imem_addr = pre-increment pointer and the word on imem_wdata. count increments on the same edge that raises imem_we.
- imem_we is 1 for exactly one cycle per legal word. The pointer wraps only by reset or start; it never exceeds DEPTH-1.
- The write of the final word (in_last, or count reaching DEPTH) still completes in the cycle after the transition to DONE. done rises on the same edge as that imem_we.
- Illegal bundle, default build: no write. err=1 and state ERR on the next edge. in_ready drops on the next edge.
- rst during a pending write cancels it: imem_we=0 on the following cycle.

Optional Feature:
ILLEGAL_SKIP_EN
- Defined: an illegal bundle is consumed and dropped. No write, no pointer advance, state stays RUN. err is set sticky and err_cnt increments, saturating at 255. If the dropped bundle had in_last=1, go to DONE.
- Undefined: illegal bundle goes to ERR as above; err_cnt is held at 0.

Test Plan:
- rst, then start, then lw bundle with rs=1, rt=2, imm=0x0010, in_last=1 -> one cycle later imem_we=1, addr 0, wdata 0x8C220010; done=1; count=1.
- start, then six back-to-back bundles lw/sw/R(rd=3, funct=0x20)/addi/beq/j(target=0x0000040) -> consecutive writes at addr 0..5, wdata 0x8C220010, 0xAC220010, 0x00221820, 0x20220010, 0x10220010, 0x08000040; no bubbles.
- in_valid toggling every other cycle -> writes only follow accepts; addresses stay contiguous.
- bundle ALUOp=11 (default build) -> no imem_we; err=1; state ERR; in_ready=0; a later start clears err.
- DEPTH=4 with 6 valid bundles, no in_last -> exactly 4 writes, done=1, in_ready=0 afterwards.
- rst asserted the cycle after an accept -> imem_we=0 next cycle; all outputs at reset values. With ILLEGAL_SKIP_EN: legal, illegal, legal -> writes at addr 0 and 1, err_cnt=1.

Source files
------------

// File: rtl/mips_instr_encoder_if.sv
`default_nettype none
// =============================================================================
// Module   : mips_instr_encoder_if
// Purpose  : Control-bundle input, instruction-memory write port and status
//            signals of the MIPS instruction encoder.
// Revision : 1.0 - initial release
// =============================================================================
interface mips_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              Jump;
    logic              MemWrite;
    logic              RegWrite;
    logic              RegDest;
    logic              ALUSrc;
    logic              MemtoReg;
    logic              Branch;
    logic [1:0]        ALUOp;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        err_cnt;

    modport master (
        output start, in_valid, in_last,
        output Jump, MemWrite, RegWrite, RegDest, ALUSrc, MemtoReg, Branch, ALUOp,
        output rs, rt, rd, funct, imm, target,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err, err_cnt
    );

    modport slave (
        input  start, in_valid, in_last,
        input  Jump, MemWrite, RegWrite, RegDest, ALUSrc, MemtoReg, Branch, ALUOp,
        input  rs, rt, rd, funct, imm, target,
        output in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// =============================================================================
// Module   : mips_instr_encoder
// Purpose  : Recovers the opcode from a main-decoder control bundle, packs a
//            32-bit MIPS word and streams words into instruction memory.
//            Optional macro ILLEGAL_SKIP_EN: drop illegal bundles and count them.
// Revision : 1.0 - initial release
// =============================================================================
module mips_instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mips_instr_encoder_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Bundle order: Jump, MemWrite, RegWrite, RegDest, ALUSrc, MemtoReg, Branch, ALUOp
    localparam logic [8:0] c_CTRL_LW   = 9'b0_0_1_0_1_1_0_00;
    localparam logic [8:0] c_CTRL_SW   = 9'b0_1_0_0_1_1_0_00;
    localparam logic [8:0] c_CTRL_R    = 9'b0_0_1_1_0_0_0_10;
    localparam logic [8:0] c_CTRL_ADDI = 9'b0_0_1_0_1_0_0_00;
    localparam logic [8:0] c_CTRL_BEQ  = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] c_CTRL_J    = 9'b1_0_0_0_0_0_0_00;

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_err;

    logic [8:0]        w_ctrl;
    logic              w_legal;
    logic [31:0]       w_word;
    logic              w_in_ready;
    logic              w_busy;
    logic              w_xfer;
    logic              w_restart;
    logic              w_depth_hit;

    assign w_ctrl = {bus.Jump, bus.MemWrite, bus.RegWrite, bus.RegDest,
                     bus.ALUSrc, bus.MemtoReg, bus.Branch, bus.ALUOp};

    always_comb begin
        w_legal = 1'b1;
        w_word  = 32'd0;
        case (w_ctrl)
            c_CTRL_LW:   w_word = {6'b100011, bus.rs, bus.rt, bus.imm};
            c_CTRL_SW:   w_word = {6'b101011, bus.rs, bus.rt, bus.imm};
            c_CTRL_R:    w_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, bus.funct};
            c_CTRL_ADDI: w_word = {6'b001000, bus.rs, bus.rt, bus.imm};
            c_CTRL_BEQ:  w_word = {6'b000100, bus.rs, bus.rt, bus.imm};
            c_CTRL_J:    w_word = {6'b000010, bus.target};
            default:     w_legal = 1'b0;
        endcase
    end

    assign w_xfer      = bus.in_valid && w_in_ready;
    assign w_restart   = bus.start && (r_state != S_RUN);
    assign w_depth_hit = ((r_count + 1'b1) == c_DEPTH);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (w_xfer) begin
                    if (w_legal) begin
                        if (bus.in_last || w_depth_hit) w_next_state = S_DONE;
                    end else begin
`ifdef ILLEGAL_SKIP_EN
                        if (bus.in_last) w_next_state = S_DONE;
`else
                        w_next_state = S_ERR;
`endif
                    end
                end
            end
            default: begin
                if (bus.start) w_next_state = S_RUN;
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        if (r_state == S_RUN) begin
            w_busy     = 1'b1;
            w_in_ready = (r_count < c_DEPTH);
        end
    end

    // Registered write port; count advances on the edge that raises imem_we
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_restart) begin
                r_count <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_xfer) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_count[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_count <= r_count + 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
                if (w_next_state == S_DONE) r_done <= 1'b1;
            end
        end
    end

`ifdef ILLEGAL_SKIP_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_restart) begin
            r_err_cnt <= 8'd0;
        end else if (w_xfer && !w_legal && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = 8'd0;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = w_busy;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.count      = r_count;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// =============================================================================
// Module   : tb_mips_instr_encoder
// Purpose  : Self-checking bench: directed program loads plus random traffic
//            compared every cycle against a table-driven reference model.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_mips_instr_encoder;
    localparam int AW  = 3;
    localparam int DEP = 8;

    localparam logic [8:0] CTRL_TAB [6] = '{9'b001011000, 9'b010011000, 9'b001100010,
                                            9'b001010000, 9'b000000101, 9'b100000000};
    localparam logic [5:0] OP_TAB   [6] = '{6'd35, 6'd43, 6'd0, 6'd8, 6'd4, 6'd2};
    localparam logic [8:0] CTRL_BAD = 9'b001011011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_instr_encoder_if #(.ADDR_W(AW)) bus ();
    mips_instr_encoder #(.ADDR_W(AW), .DEPTH(DEP)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_run, m_done, m_err, m_we;
    int          m_cnt, m_ecnt;
    logic [31:0] m_addr, m_data;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {legal, word} from the canonical-vector table and field arithmetic
    function automatic logic [32:0] ref_encode();
        logic [8:0]  ctrl;
        logic [31:0] op;
        ctrl = {bus.Jump, bus.MemWrite, bus.RegWrite, bus.RegDest,
                bus.ALUSrc, bus.MemtoReg, bus.Branch, bus.ALUOp};
        for (int i = 0; i < 6; i++) begin
            if (ctrl == CTRL_TAB[i]) begin
                op = 32'(OP_TAB[i]) * 32'h0400_0000;
                if (i == 5) return {1'b1, op + 32'(bus.target)};
                if (i == 2) return {1'b1, op + 32'(bus.rs) * 32'h20_0000 + 32'(bus.rt) * 32'h1_0000
                                          + 32'(bus.rd) * 32'h800 + 32'(bus.funct)};
                return {1'b1, op + 32'(bus.rs) * 32'h20_0000 + 32'(bus.rt) * 32'h1_0000 + 32'(bus.imm)};
            end
        end
        return 33'd0;
    endfunction

    task automatic model();
        logic [32:0] enc;
        bit          rdy;
        if (rst) begin
            m_run = 0; m_done = 0; m_err = 0; m_we = 0;
            m_cnt = 0; m_ecnt = 0; m_addr = 0; m_data = 0;
        end else begin
            rdy  = m_run && (m_cnt < DEP);
            m_we = 0;
            if (bus.start && !m_run) begin
                m_run = 1; m_cnt = 0; m_done = 0; m_err = 0; m_ecnt = 0;
            end else if (bus.in_valid && rdy) begin
                enc = ref_encode();
                if (enc[32]) begin
                    m_we = 1; m_addr = 32'(m_cnt); m_data = enc[31:0];
                    m_cnt++;
                    if (bus.in_last || m_cnt == DEP) begin m_run = 0; m_done = 1; end
                end else begin
                    m_err = 1;
`ifdef ILLEGAL_SKIP_EN
                    if (m_ecnt < 255) m_ecnt++;
                    if (bus.in_last) begin m_run = 0; m_done = 1; end
`else
                    m_run = 0;
`endif
                end
            end
        end
    endtask

    task automatic compare();
        chk("imem_we", 32'(bus.imem_we), 32'(m_we));
        chk("imem_addr", 32'(bus.imem_addr), m_addr);
        chk("imem_wdata", bus.imem_wdata, m_data);
        chk("count", 32'(bus.count), 32'(m_cnt));
        chk("in_ready", 32'(bus.in_ready), 32'(m_run && (m_cnt < DEP)));
        chk("busy", 32'(bus.busy), 32'(m_run));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("err_cnt", 32'(bus.err_cnt), 32'(m_ecnt));
        if (bus.imem_we === 1'b1) begin
            log_addr.push_back(32'(bus.imem_addr));
            log_data.push_back(bus.imem_wdata);
        end
    endtask

    // Inputs change at negedge; model and DUT both see them at the next posedge
    task automatic step();
        @(posedge clk);
        model();
        @(negedge clk);
        compare();
    endtask

    task automatic set_ctrl(input logic [8:0] c);
        {bus.Jump, bus.MemWrite, bus.RegWrite, bus.RegDest,
         bus.ALUSrc, bus.MemtoReg, bus.Branch, bus.ALUOp} = c;
    endtask

    task automatic set_fixed(input int idx, input logic last);
        set_ctrl(CTRL_TAB[idx]);
        bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3; bus.funct = 6'h20;
        bus.imm = 16'h0010; bus.target = 26'h40;
        bus.in_valid = 1'b1; bus.in_last = last;
    endtask

    task automatic rand_bundle(input int illegal_pct);
        if (int'($urandom_range(0, 99)) < illegal_pct) set_ctrl(9'($urandom));
        else set_ctrl(CTRL_TAB[$urandom_range(0, 5)]);
        bus.rs = 5'($urandom); bus.rt = 5'($urandom); bus.rd = 5'($urandom);
        bus.funct = 6'($urandom); bus.imm = 16'($urandom); bus.target = 26'($urandom);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; bus.in_valid = 1'b0;
        step();
        bus.start = 1'b0;
        log_addr.delete(); log_data.delete();
    endtask

    logic [31:0] exp6 [6] = '{32'h8C220010, 32'hAC220010, 32'h00221820,
                              32'h20220010, 32'h10220010, 32'h08000040};

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.in_valid = 0; bus.in_last = 0;
        set_ctrl(9'd0);
        bus.rs = 0; bus.rt = 0; bus.rd = 0; bus.funct = 0; bus.imm = 0; bus.target = 0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        step();

        // Single lw with in_last
        pulse_start();
        set_fixed(0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("tp1_we", 32'(bus.imem_we), 32'd1);
        chk("tp1_addr", 32'(bus.imem_addr), 32'd0);
        chk("tp1_wdata", bus.imem_wdata, 32'h8C220010);
        chk("tp1_done", 32'(bus.done), 32'd1);
        chk("tp1_count", 32'(bus.count), 32'd1);
        step();

        // Six back-to-back canonical instructions
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            set_fixed(i, i == 5);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("tp2_nwrites", 32'(log_data.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_data.size(); i++) begin
            chk("tp2_addr", log_addr[i], 32'(i));
            chk("tp2_wdata", log_data[i], exp6[i]);
        end

        // in_valid toggling: writes only after accepts, contiguous addresses
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            rand_bundle(0);
            bus.in_valid = (i % 2 == 0);
            bus.in_last  = (i == 8);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("tp3_nwrites", 32'(log_addr.size()), 32'd5);
        for (int i = 0; i < log_addr.size(); i++) chk("tp3_addr", log_addr[i], 32'(i));

        // Illegal ALUOp=11 after one legal word
        pulse_start();
        set_fixed(1, 1'b0);
        step();
        set_ctrl(CTRL_BAD);
        step();
        bus.in_valid = 1'b0;
        chk("tp4_nowrite", 32'(bus.imem_we), 32'd0);
        chk("tp4_err", 32'(bus.err), 32'd1);
`ifdef ILLEGAL_SKIP_EN
        chk("tp4_errcnt", 32'(bus.err_cnt), 32'd1);
        chk("tp4_ready", 32'(bus.in_ready), 32'd1);
        set_fixed(2, 1'b1);
        step();
        chk("tp4_addr2", 32'(bus.imem_addr), 32'd1);
        bus.in_valid = 1'b0;
`else
        chk("tp4_ready", 32'(bus.in_ready), 32'd0);
`endif
        step(); step();
        pulse_start();
        chk("tp4_err_cleared", 32'(bus.err), 32'd0);

        // Depth limit with no in_last: exactly DEP writes
        pulse_start();
        for (int i = 0; i < DEP + 2; i++) begin
            rand_bundle(0);
            bus.in_valid = 1'b1; bus.in_last = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("tp5_nwrites", 32'(log_addr.size()), 32'(DEP));
        chk("tp5_done", 32'(bus.done), 32'd1);
        chk("tp5_ready", 32'(bus.in_ready), 32'd0);

        // Reset the cycle after an accept
        pulse_start();
        set_fixed(3, 1'b0);
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("tp6_we", 32'(bus.imem_we), 32'd0);
        chk("tp6_count", 32'(bus.count), 32'd0);
        chk("tp6_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            bus.start = ($urandom_range(0, 9) == 0);
            rand_bundle(8);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_last  = ($urandom_range(0, 11) == 0);
            step();
        end
        rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
